// File: rtl/phy_loopback_sequencer.sv
// RMII loopback self-test master for the PHY register block.
// Loads an LFSR TX package, triggers TX and polls for rx_good.
module phy_loopback_sequencer #(
    parameter int SETTLE_CYC  = 8,
    parameter int POLL_GAP    = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        START,
    input  logic        STOP,
    input  logic [15:0] NUM_ITER,
    input  logic [31:0] SEED,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_DI,
    output logic        M_WE,
    output logic        M_RE,
    input  logic [31:0] M_DO,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] PASS_CNT,
    output logic [15:0] FAIL_CNT,
    output logic [7:0]  LAST_BITCNT,
    output logic        ERR_TIMEOUT
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_TX, S_WR_CTRL, S_WAIT, S_POLL_RD,
        S_POLL_CHK, S_GAP, S_NEXT, S_CLR_CTRL, S_FIN
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [15:0] num_q, num_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] fail_q, fail_d;
    logic [7:0]  bitcnt_q, bitcnt_d;
    logic        err_q, err_d;
    logic        res_q, res_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] di_q, di_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] total;
    logic [31:0] seed_v;
    logic        unused_do;

    assign unused_do = ^{M_DO[31:10], M_DO[0]};

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tmo_d    = (tmo_q != '1) ? tmo_q + 32'd1 : tmo_q;
        num_d    = num_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        bitcnt_d = bitcnt_q;
        err_d    = err_q;
        res_d    = res_q;
        total    = '0;
        seed_v   = (SEED == 32'h0) ? 32'h1 : SEED;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    lfsr_d  = lfsr_step(seed_v);
                    idx_d   = 2'd0;
                    num_d   = NUM_ITER;
                    pass_d  = '0;
                    fail_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_WR_TX;
                end
            end
            S_WR_TX: begin
                if (idx_q == 2'd3) begin
                    state_d = S_WR_CTRL;
                end else begin
                    idx_d  = idx_q + 2'd1;
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            S_WR_CTRL: begin
                tmo_d   = 32'd1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 32'(SETTLE_CYC - 1)) state_d = S_POLL_RD;
                else cnt_d = cnt_q + 32'd1;
            end
            S_POLL_RD: state_d = S_POLL_CHK;
            S_POLL_CHK: begin
                bitcnt_d = M_DO[9:2];
                cnt_d    = '0;
                if (M_DO[1]) begin
                    res_d   = 1'b1;
                    state_d = S_NEXT;
                end else if (tmo_q >= 32'(TIMEOUT_CYC)) begin
                    res_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == 32'(POLL_GAP - 1)) state_d = S_POLL_RD;
                else cnt_d = cnt_q + 32'd1;
            end
            S_NEXT: begin
                if (res_q && pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
                if (!res_q && fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
                total = {1'b0, pass_d} + {1'b0, fail_d};
                if (num_q != 16'd0 && total == {1'b0, num_q}) begin
                    state_d = S_CLR_CTRL;
                end else begin
                    idx_d   = 2'd0;
                    lfsr_d  = lfsr_step(lfsr_q);
                    state_d = S_WR_TX;
                end
            end
            S_CLR_CTRL: state_d = S_FIN;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Abort: the in-flight iteration leaves no trace in the counters.
        if (STOP && state_q != S_IDLE && state_q != S_CLR_CTRL &&
            state_q != S_FIN) begin
            state_d  = S_CLR_CTRL;
            lfsr_d   = lfsr_q;
            idx_d    = idx_q;
            pass_d   = pass_q;
            fail_d   = fail_q;
            err_d    = err_q;
            bitcnt_d = bitcnt_q;
        end

        we_d   = 1'b0;
        re_d   = 1'b0;
        addr_d = '0;
        di_d   = '0;
        case (state_d)
            S_WR_TX: begin
                we_d   = 1'b1;
                addr_d = {27'd0, 1'b1, 2'b00, idx_d};
                di_d   = lfsr_d;
            end
            S_WR_CTRL: begin
                we_d   = 1'b1;
                addr_d = 32'h1;
                di_d   = 32'h1;
            end
            S_POLL_RD: begin
                re_d   = 1'b1;
                addr_d = 32'h2;
            end
            S_CLR_CTRL: begin
                we_d   = 1'b1;
                addr_d = 32'h1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 32'h1;
            idx_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            num_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            bitcnt_q <= '0;
            err_q    <= 1'b0;
            res_q    <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            addr_q   <= '0;
            di_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            num_q    <= num_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            bitcnt_q <= bitcnt_d;
            err_q    <= err_d;
            res_q    <= res_d;
            we_q     <= we_d;
            re_q     <= re_d;
            addr_q   <= addr_d;
            di_q     <= di_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign M_ADDR      = addr_q;
    assign M_DI        = di_q;
    assign M_WE        = we_q;
    assign M_RE        = re_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign PASS_CNT    = pass_q;
    assign FAIL_CNT    = fail_q;
    assign LAST_BITCNT = bitcnt_q;
    assign ERR_TIMEOUT = err_q;

endmodule
